execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of the integer pipeline.
// Single-cycle ALU ops resolve combinationally in IDLE. MUL/MULHU/DIVU/REMU
// run as a 32-iteration sequential unit (IDLE -> BUSY x32 -> DONE) and hold
// the front end with stall while they run.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   flush                   kills the instruction currently in EX
//   id_valid, id_alu_op, id_operand_a, id_operand_b, id_rd, id_reg_write
//                           instruction presented by decode
//   ex_alu_result, ex_rd, ex_reg_write
//                           payload for the EX/WB pipeline register
//   stall                   decode must hold the id_* inputs while high
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_operand_a,
    input  logic [31:0] id_operand_b,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    output logic [31:0] ex_alu_result,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        stall
);

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [4:0]     cnt_q;
    logic [3:0]     op_q;
    logic [4:0]     rd_q;
    logic           wr_q;
    // m_q: multiplicand (MUL) or divisor (DIV).
    // hi_q/lo_q: {accumulator, multiplier} for MUL, {remainder, dividend/quotient} for DIV.
    logic [W-1:0]   m_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           is_multi_c;
    logic           is_mul_op_c;
    logic [W-1:0]   alu_c;
    logic [W:0]     mul_sum_c;
    logic [W:0]     div_shift_c;
    logic           div_ge_c;
    logic [W-1:0]   done_result_c;

    assign is_multi_c  = (id_alu_op >= OP_MUL) && (id_alu_op <= OP_REMU);
    assign is_mul_op_c = (op_q == OP_MUL) || (op_q == OP_MULHU);

    // Single-cycle ALU; multicycle codes never reach the output from here.
    always_comb begin
        alu_c = id_operand_a + id_operand_b;
        case (id_alu_op)
            OP_SUB:  alu_c = id_operand_a - id_operand_b;
            OP_AND:  alu_c = id_operand_a & id_operand_b;
            OP_OR:   alu_c = id_operand_a | id_operand_b;
            OP_XOR:  alu_c = id_operand_a ^ id_operand_b;
            OP_SLL:  alu_c = id_operand_a << id_operand_b[4:0];
            OP_SRL:  alu_c = id_operand_a >> id_operand_b[4:0];
            OP_SRA:  alu_c = W'($signed(id_operand_a) >>> id_operand_b[4:0]);
            OP_SLT:  alu_c = {31'd0, $signed(id_operand_a) < $signed(id_operand_b)};
            OP_SLTU: alu_c = {31'd0, id_operand_a < id_operand_b};
            default: alu_c = id_operand_a + id_operand_b;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        div_shift_c = {hi_q, lo_q[W-1]};
        div_ge_c    = div_shift_c >= {1'b0, m_q};
    end

    always_comb begin
        done_result_c = lo_q;
        case (op_q)
            OP_MULHU, OP_REMU: done_result_c = hi_q;
            default:           done_result_c = lo_q;
        endcase
    end

    // State, latched instruction and iterative datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 4'd0;
            rd_q    <= 5'd0;
            wr_q    <= 1'b0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_valid && !flush && is_multi_c) begin
                        state_q <= BUSY;
                        cnt_q   <= 5'd0;
                        op_q    <= id_alu_op;
                        rd_q    <= id_rd;
                        wr_q    <= id_reg_write;
                        hi_q    <= '0;
                        if ((id_alu_op == OP_MUL) || (id_alu_op == OP_MULHU)) begin
                            m_q  <= id_operand_a;
                            lo_q <= id_operand_b;
                        end else begin
                            m_q  <= id_operand_b;
                            lo_q <= id_operand_a;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        if (is_mul_op_c) begin
                            hi_q <= mul_sum_c[W:1];
                            lo_q <= {mul_sum_c[0], lo_q[W-1:1]};
                        end else if (div_ge_c) begin
                            hi_q <= W'(div_shift_c - {1'b0, m_q});
                            lo_q <= {lo_q[W-2:0], 1'b1};
                        end else begin
                            hi_q <= div_shift_c[W-1:0];
                            lo_q <= {lo_q[W-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode; IDLE results pass straight through from the ALU.
    always_comb begin
        ex_alu_result = '0;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        stall         = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (id_valid && !flush) begin
                        if (is_multi_c) begin
                            stall = 1'b1;
                        end else begin
                            ex_alu_result = alu_c;
                            ex_rd         = id_rd;
                            ex_reg_write  = id_reg_write;
                        end
                    end
                end
                BUSY: begin
                    stall = !flush;
                end
                DONE: begin
                    ex_alu_result = done_result_c;
                    ex_rd         = rd_q;
                    ex_reg_write  = wr_q && !flush;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule
